// File: rtl/alu_wide_seq_if.sv
// Bundle between the control path, the wide ALU sequencer and the shared 8-bit ALU.
// Latency: none (wires only).
// Backpressure: none; the control side watches busy/done before issuing a new start.
//   Ports:
//   control  start/cmd/opa/opb/carry_in/abort  -> sequencer
//   status   busy/done/result/carry_out/zero_out <- sequencer
//   alu      alu_a/alu_b/alu_op/alu_funct/alu_sc_in <- sequencer, alu_out/alu_sc_out -> sequencer
interface alu_wide_seq_if #(
    parameter int NBYTES = 2
);
    localparam int W = 8 * NBYTES;

    logic         start;
    logic [1:0]   cmd;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         carry_in;
    logic         abort;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero_out;
    logic [7:0]   alu_a;
    logic [7:0]   alu_b;
    logic [1:0]   alu_op;
    logic [1:0]   alu_funct;
    logic         alu_sc_in;
    logic [7:0]   alu_out;
    logic         alu_sc_out;

    // Environment side: control path plus the shared ALU.
    modport master (
        output start, cmd, opa, opb, carry_in, abort, alu_out, alu_sc_out,
        input  busy, done, result, carry_out, zero_out,
        input  alu_a, alu_b, alu_op, alu_funct, alu_sc_in
    );

    // Sequencer side.
    modport slave (
        input  start, cmd, opa, opb, carry_in, abort, alu_out, alu_sc_out,
        output busy, done, result, carry_out, zero_out,
        output alu_a, alu_b, alu_op, alu_funct, alu_sc_in
    );
endinterface

// File: rtl/alu_wide_seq.sv
// Byte-serial sequencer running NBYTES-wide ADD/RSH/XOR/AND on a shared 8-bit ALU.
// Latency: done pulses NBYTES edges after the edge that samples start.
// Backpressure: start ignored while busy; abort cancels a running op without done.
//   Ports: clk, rst (async active-high), bus (alu_wide_seq_if.slave: control,
//   status and the ALU drive/return signals).
module alu_wide_seq #(
    parameter int         NBYTES = 2,
    parameter logic [3:0] P_ADD  = 4'b0000,
    parameter logic [3:0] P_RSH  = 4'b0001,
    parameter logic [3:0] P_XOR  = 4'b0010,
    parameter logic [3:0] P_AND  = 4'b0011,
    parameter logic [3:0] P_NOP  = 4'b1111
) (
    input  logic           clk,
    input  logic           rst,
    alu_wide_seq_if.slave  bus
);
    localparam int              W    = 8 * NBYTES;
    localparam int              IW   = $clog2(NBYTES);
    localparam logic [IW-1:0]   LAST = IW'(NBYTES - 1);

    localparam logic [1:0] C_ADD = 2'b00;
    localparam logic [1:0] C_RSH = 2'b01;
    localparam logic [1:0] C_XOR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         state, state_nx;
    logic [IW-1:0]  idx;
    logic           chain;
    logic [1:0]     cmd_r;
    logic [W-1:0]   opa_r;
    logic [W-1:0]   opb_r;
    logic [W-1:0]   work;

    logic [IW-1:0]  bsel;
    logic [3:0]     code;
    logic [W-1:0]   work_nx;
    logic           chain_nx;
    logic           load;
    logic           step;
    logic           last_step;

    assign load      = (state != S_RUN) && bus.start;
    assign step      = (state == S_RUN) && !bus.abort;
    assign last_step = (idx == LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_RUN;
            S_RUN: begin
                if (bus.abort)      state_nx = S_IDLE;
                else if (last_step) state_nx = S_DONE;
            end
            S_DONE:  state_nx = bus.start ? S_RUN : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- byte selection and chain ----------------
    // RSH walks MSB first so each byte's bit0 becomes the next lower byte's bit7.
    always_comb begin
        bsel = (cmd_r == C_RSH) ? (LAST - idx) : idx;
        case (cmd_r)
            C_ADD:   code = P_ADD;
            C_RSH:   code = P_RSH;
            C_XOR:   code = P_XOR;
            default: code = P_AND;
        endcase
        work_nx = work;
        work_nx[int'(bsel) * 8 +: 8] = bus.alu_out;
        // Logic ops never produce a carry; ignore whatever the ALU reports.
        chain_nx = cmd_r[1] ? 1'b0 : bus.alu_sc_out;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.busy      = (state == S_RUN);
        bus.done      = (state == S_DONE);
        bus.alu_a     = 8'h00;
        bus.alu_b     = 8'h00;
        bus.alu_sc_in = 1'b0;
        {bus.alu_op, bus.alu_funct} = P_NOP;
        if (state == S_RUN) begin
            bus.alu_a     = opa_r[int'(bsel) * 8 +: 8];
            bus.alu_b     = opb_r[int'(bsel) * 8 +: 8];
            bus.alu_sc_in = chain;
            {bus.alu_op, bus.alu_funct} = code;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx           <= '0;
            chain         <= 1'b0;
            cmd_r         <= 2'b00;
            opa_r         <= '0;
            opb_r         <= '0;
            work          <= '0;
            bus.result    <= '0;
            bus.carry_out <= 1'b0;
            bus.zero_out  <= 1'b1;
        end else if (load) begin
            opa_r <= bus.opa;
            opb_r <= bus.opb;
            cmd_r <= bus.cmd;
            idx   <= '0;
            work  <= '0;
            chain <= bus.cmd[1] ? 1'b0 : bus.carry_in;
        end else if (step) begin
            work  <= work_nx;
            chain <= chain_nx;
            idx   <= last_step ? '0 : idx + 1'b1;
            // Status outputs change together, only on a completed op.
            if (last_step) begin
                bus.result    <= work_nx;
                bus.carry_out <= chain_nx;
                bus.zero_out  <= (work_nx == '0);
            end
        end
    end
endmodule
